// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock; 4*DIGITS+1 edges from accept to done.
// No backpressure: start is ignored while busy. Define BCD_TO_BIN_SAT_EN to saturate binary on err instead of zeroing it.
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int EW = (BIN_W > W) ? BIN_W : W;
  localparam int CW = $clog2(W + 1);

`ifdef BCD_TO_BIN_SAT_EN
  localparam logic [BIN_W-1:0] ERR_VAL = '1;
`else
  localparam logic [BIN_W-1:0] ERR_VAL = '0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     bcd_q, bcd_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inv_q, inv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BIN_W-1:0] binary_q, binary_d;
  logic             err_q, err_d;

  logic             invalid_in;
  logic [W-1:0]     sh_bcd;
  logic [W-1:0]     sh_acc;
  logic [W-1:0]     bcd_corr;
  logic [EW-1:0]    acc_ext;
  logic             ovf;

  always_comb begin
    invalid_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) invalid_in = 1'b1;
    end
  end

  // The shift moves the BCD LSB into the accumulator MSB; each nibble is then corrected.
  always_comb begin
    {sh_bcd, sh_acc} = {bcd_q, acc_q} >> 1;
    bcd_corr = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8) bcd_corr[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    acc_ext = EW'(acc_q);
    ovf     = |(acc_q >> BIN_W);
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    binary_d = binary_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd;
          acc_d   = '0;
          cnt_d   = '0;
          inv_d   = invalid_in;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_corr;
        acc_d = sh_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = FINISH;
      end
      FINISH: begin
        err_d    = inv_q | ovf;
        binary_d = (inv_q | ovf) ? ERR_VAL : acc_ext[BIN_W-1:0];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      binary_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      binary_q <= binary_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: a 14-bit instance for function/latency/reset and a 10-bit instance for overflow.
module tb_bcd_to_binary;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] bcd_a, bcd_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic [13:0] binary_a;
  logic [9:0]  binary_b;
  logic        err_a, err_b;

  int total = 0;
  int bad   = 0;
  int done_cnt_a = 0;
  logic        done_prev_a = 1'b0;
  logic [16:0] exp_q_a[$];
  logic [16:0] exp_q_b[$];

  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bcd(bcd_a),
    .busy(busy_a), .done(done_a), .binary(binary_a), .err(err_a)
  );

  bcd_to_binary #(.DIGITS(4), .BIN_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bcd(bcd_b),
    .busy(busy_b), .done(done_b), .binary(binary_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal value of the digits, error on a non-decimal digit or a value beyond bw bits.
  function automatic logic [16:0] model(input logic [15:0] v, input int bw);
    int   val;
    logic e;
    logic [3:0] d;
    val = 0;
    e   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
      val = val * 10 + int'(d);
    end
    if (val >= (1 << bw)) e = 1'b1;
    if (e) begin
`ifdef BCD_TO_BIN_SAT_EN
      val = (1 << bw) - 1;
`else
      val = 0;
`endif
    end
    return {e, val[15:0]};
  endfunction

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (done_a) begin
        done_cnt_a++;
        if (done_prev_a) chk("done_a_width", 32'd1, 32'd0);
        if (exp_q_a.size() == 0) chk("done_a_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q_a.pop_front();
          chk("binary_a", 32'(binary_a), 32'(e[15:0]));
          chk("err_a", 32'(err_a), 32'(e[16]));
        end
      end
      if (done_b) begin
        if (exp_q_b.size() == 0) chk("done_b_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q_b.pop_front();
          chk("binary_b", 32'(binary_b), 32'(e[15:0]));
          chk("err_b", 32'(err_b), 32'(e[16]));
        end
      end
    end
    done_prev_a = done_a;
  end

  // One conversion on instance a (which=0) or b (which=1); checks busy and the accept-to-done edge count.
  task automatic do_conv(input int which, input logic [15:0] v);
    int   n;
    logic seen;
    @(negedge clk);
    if (which == 0) begin
      bcd_a = v; start_a = 1'b1; exp_q_a.push_back(model(v, 14));
    end else begin
      bcd_b = v; start_b = 1'b1; exp_q_b.push_back(model(v, 10));
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_accept", 32'((which == 0) ? busy_a : busy_b), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if ((which == 0) ? done_a : done_b) seen = 1'b1;
      else chk("busy_during", 32'((which == 0) ? busy_a : busy_b), 32'd1);
    end
    chk("latency", 32'(n), 32'd17);
    chk("busy_in_done", 32'((which == 0) ? busy_a : busy_b), 32'd0);
  endtask

  initial begin
    int d1, d2, cnt_before;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bcd_a   = '0;
    bcd_b   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_binary", 32'(binary_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;

    do_conv(0, 16'h1234);
    do_conv(0, 16'h9999);
    do_conv(0, 16'h0000);
    do_conv(0, 16'h12A4);
    do_conv(0, 16'h0F00);
    do_conv(1, 16'h1023);
    do_conv(1, 16'h1024);
    do_conv(1, 16'h9999);

    // Back-to-back: start held; bcd wiggled while busy must not reach the first result.
    @(negedge clk);
    bcd_a   = 16'h0042;
    start_a = 1'b1;
    exp_q_a.push_back(model(16'h0042, 14));
    exp_q_a.push_back(model(16'h0042, 14));
    d1 = 0;
    d2 = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        if (d1 == 0) d1 = k;
        else d2 = k;
      end
      if (k == 5)  bcd_a = 16'h0077;
      if (k == 10) bcd_a = 16'h0042;
      if (k == 36) start_a = 1'b0;
    end
    chk("b2b_done1_edge", 32'(d1), 32'd18);
    chk("b2b_done2_edge", 32'(d2), 32'd36);

    // Asynchronous abort between edges 8 and 9.
    @(negedge clk);
    bcd_a   = 16'h5678;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_binary", 32'(binary_a), 32'd0);
    chk("abort_err", 32'(err_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_before = done_cnt_a;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt_a), 32'(cnt_before));
    do_conv(0, 16'h0007);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 32'(exp_q_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
